// File: rtl/falling_edge_gen.sv
// Generates a burst of falling edges with programmable low/high phase lengths.
// The counterpart receiver is a falling-edge detector on the same clock.
//
// state | meaning
// IDLE  | dout held high, waiting for start
// LOW   | low phase; first cycle carries edge_strobe
// HIGH  | high phase; last cycle decides next edge or done
module falling_edge_gen #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] low_len_i,
  input  logic [LEN_W-1:0] high_len_i,
  input  logic [CNT_W-1:0] num_edges_i,
  output logic             dout_o,
  output logic             edge_strobe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] edge_cnt_o
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] low_len_q, low_len_d;
  logic [LEN_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [LEN_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             dout_q, dout_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Phase counter holds the cycles remaining after the current one; a zero
  // length is treated as one cycle, so it loads 0 in that case.
  logic [LEN_W-1:0] low_ld, low_run, high_run;
  assign low_ld   = (low_len_i  == '0) ? '0 : low_len_i  - 1'b1;
  assign low_run  = (low_len_q  == '0) ? '0 : low_len_q  - 1'b1;
  assign high_run = (high_len_q == '0) ? '0 : high_len_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    low_len_d  = low_len_q;
    high_len_d = high_len_q;
    num_d      = num_q;
    phase_d    = phase_q;
    edge_cnt_d = edge_cnt_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_edges_i == '0) begin
            done_d     = 1'b1;
            edge_cnt_d = '0;
          end else begin
            state_d    = LOW;
            low_len_d  = low_len_i;
            high_len_d = high_len_i;
            num_d      = num_edges_i;
            phase_d    = low_ld;
            edge_cnt_d = CNT_W'(1);
            dout_d     = 1'b0;
            strobe_d   = 1'b1;
            busy_d     = 1'b1;
          end
        end
      end
      LOW: begin
        if (phase_q == '0) begin
          state_d = HIGH;
          phase_d = high_run;
          dout_d  = 1'b1;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      HIGH: begin
        if (phase_q != '0) begin
          phase_d = phase_q - 1'b1;
        end else if (edge_cnt_q == num_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d    = LOW;
          phase_d    = low_run;
          edge_cnt_d = edge_cnt_q + 1'b1;
          dout_d     = 1'b0;
          strobe_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over everything but reset and keeps the issued edge count.
    if (abort_i) begin
      state_d    = IDLE;
      phase_d    = '0;
      edge_cnt_d = edge_cnt_q;
      dout_d     = 1'b1;
      strobe_d   = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      low_len_q  <= '0;
      high_len_q <= '0;
      num_q      <= '0;
      phase_q    <= '0;
      edge_cnt_q <= '0;
      dout_q     <= 1'b1;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      low_len_q  <= low_len_d;
      high_len_q <= high_len_d;
      num_q      <= num_d;
      phase_q    <= phase_d;
      edge_cnt_q <= edge_cnt_d;
      dout_q     <= dout_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dout_o        = dout_q;
  assign edge_strobe_o = strobe_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign edge_cnt_o    = edge_cnt_q;

endmodule

// File: tb/tb_falling_edge_gen.sv
// Directed self-checking bench for falling_edge_gen; offsets count clock
// edges after the one that samples start.
module tb_falling_edge_gen;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       abort_i;
  logic [7:0] low_len_i;
  logic [7:0] high_len_i;
  logic [7:0] num_edges_i;
  logic       dout_o;
  logic       edge_strobe_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] edge_cnt_o;

  int tests = 0;
  int fails = 0;

  falling_edge_gen #(.LEN_W(8), .CNT_W(8)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .low_len_i     (low_len_i),
    .high_len_i    (high_len_i),
    .num_edges_i   (num_edges_i),
    .dout_o        (dout_o),
    .edge_strobe_o (edge_strobe_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .edge_cnt_o    (edge_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    tests++; if (dout_o !== 1'b1) begin fails++; $display("FAIL reset_dout got %b want 1", dout_o); end
    tests++; if (edge_strobe_o !== 1'b0) begin fails++; $display("FAIL reset_strobe got %b want 0", edge_strobe_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_o); end
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done_o); end
    tests++; if (edge_cnt_o !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", edge_cnt_o); end
    rst_i = 1'b0;
    tick();
  endtask

  // low=2 high=3 edges=3: period 5, strobes at 1,6,11, done at 16
  task automatic test_basic();
    logic e_dout, e_strb, e_busy, e_done, prev;
    logic [7:0] e_cnt;
    int det, pos;
    low_len_i = 8'd2; high_len_i = 8'd3; num_edges_i = 8'd3;
    start_i = 1'b1;
    prev = 1'b1; det = 0;
    for (int o = 1; o <= 18; o++) begin
      tick();
      if (o == 1) start_i = 1'b0;
      pos    = (o - 1) % 5;
      e_busy = (o <= 15);
      e_dout = e_busy ? (pos >= 2) : 1'b1;
      e_strb = e_busy && (pos == 0);
      e_done = (o == 16);
      e_cnt  = e_busy ? 8'((o - 1) / 5 + 1) : 8'd3;
      tests++; if (dout_o !== e_dout) begin fails++; $display("FAIL basic_dout o=%0d got %b want %b", o, dout_o, e_dout); end
      tests++; if (edge_strobe_o !== e_strb) begin fails++; $display("FAIL basic_strobe o=%0d got %b want %b", o, edge_strobe_o, e_strb); end
      tests++; if (busy_o !== e_busy) begin fails++; $display("FAIL basic_busy o=%0d got %b want %b", o, busy_o, e_busy); end
      tests++; if (done_o !== e_done) begin fails++; $display("FAIL basic_done o=%0d got %b want %b", o, done_o, e_done); end
      tests++; if (edge_cnt_o !== e_cnt) begin fails++; $display("FAIL basic_cnt o=%0d got %0d want %0d", o, edge_cnt_o, e_cnt); end
      if (prev && !dout_o) det++;
      prev = dout_o;
    end
    tests++; if (det !== 3) begin fails++; $display("FAIL basic_detect got %0d want 3", det); end
  endtask

  // zero lengths behave as 1: dout toggles every cycle, done at offset 9
  task automatic test_min_period();
    logic e_dout, e_strb, e_busy, e_done, prev;
    logic [7:0] e_cnt;
    int det;
    low_len_i = 8'd0; high_len_i = 8'd0; num_edges_i = 8'd4;
    start_i = 1'b1;
    prev = 1'b1; det = 0;
    for (int o = 1; o <= 10; o++) begin
      tick();
      if (o == 1) start_i = 1'b0;
      e_busy = (o <= 8);
      e_dout = e_busy ? (o % 2 == 0) : 1'b1;
      e_strb = e_busy && (o % 2 == 1);
      e_done = (o == 9);
      e_cnt  = e_busy ? 8'((o + 1) / 2) : 8'd4;
      tests++; if (dout_o !== e_dout) begin fails++; $display("FAIL min_dout o=%0d got %b want %b", o, dout_o, e_dout); end
      tests++; if (edge_strobe_o !== e_strb) begin fails++; $display("FAIL min_strobe o=%0d got %b want %b", o, edge_strobe_o, e_strb); end
      tests++; if (busy_o !== e_busy) begin fails++; $display("FAIL min_busy o=%0d got %b want %b", o, busy_o, e_busy); end
      tests++; if (done_o !== e_done) begin fails++; $display("FAIL min_done o=%0d got %b want %b", o, done_o, e_done); end
      tests++; if (edge_cnt_o !== e_cnt) begin fails++; $display("FAIL min_cnt o=%0d got %0d want %0d", o, edge_cnt_o, e_cnt); end
      if (prev && !dout_o) det++;
      prev = dout_o;
    end
    tests++; if (det !== 4) begin fails++; $display("FAIL min_detect got %0d want 4", det); end
  endtask

  task automatic test_zero_edges();
    low_len_i = 8'd2; high_len_i = 8'd2; num_edges_i = 8'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL zero_done got %b want 1", done_o); end
    tests++; if (dout_o !== 1'b1) begin fails++; $display("FAIL zero_dout got %b want 1", dout_o); end
    tests++; if (edge_strobe_o !== 1'b0) begin fails++; $display("FAIL zero_strobe got %b want 0", edge_strobe_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL zero_busy got %b want 0", busy_o); end
    tests++; if (edge_cnt_o !== 8'd0) begin fails++; $display("FAIL zero_cnt got %0d want 0", edge_cnt_o); end
    tick();
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL zero_done_pulse got %b want 0", done_o); end
    tests++; if (dout_o !== 1'b1) begin fails++; $display("FAIL zero_dout2 got %b want 1", dout_o); end
  endtask

  // abort at offset 10 (2nd LOW of low=4/high=4), then abort+start, then a normal burst
  task automatic test_abort();
    low_len_i = 8'd4; high_len_i = 8'd4; num_edges_i = 8'd5;
    start_i = 1'b1;
    for (int o = 1; o <= 10; o++) begin
      tick();
      if (o == 1) start_i = 1'b0;
    end
    tests++; if (dout_o !== 1'b0) begin fails++; $display("FAIL abort_pre_dout got %b want 0", dout_o); end
    tests++; if (edge_cnt_o !== 8'd2) begin fails++; $display("FAIL abort_pre_cnt got %0d want 2", edge_cnt_o); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    tests++; if (dout_o !== 1'b1) begin fails++; $display("FAIL abort_dout got %b want 1", dout_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy_o); end
    tests++; if (edge_strobe_o !== 1'b0) begin fails++; $display("FAIL abort_strobe got %b want 0", edge_strobe_o); end
    tests++; if (edge_cnt_o !== 8'd2) begin fails++; $display("FAIL abort_cnt got %0d want 2", edge_cnt_o); end
    for (int i = 0; i < 10; i++) begin
      tests++; if (done_o !== 1'b0 || dout_o !== 1'b1 || busy_o !== 1'b0) begin
        fails++; $display("FAIL abort_quiet i=%0d got done=%b dout=%b busy=%b want 0,1,0", i, done_o, dout_o, busy_o);
      end
      tick();
    end
    abort_i = 1'b1; start_i = 1'b1;
    tick();
    abort_i = 1'b0; start_i = 1'b0;
    tests++; if (busy_o !== 1'b0 || dout_o !== 1'b1) begin fails++; $display("FAIL abort_start got busy=%b dout=%b want 0,1", busy_o, dout_o); end
    tests++; if (edge_cnt_o !== 8'd2) begin fails++; $display("FAIL abort_start_cnt got %0d want 2", edge_cnt_o); end
    low_len_i = 8'd1; high_len_i = 8'd1; num_edges_i = 8'd1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tests++; if (dout_o !== 1'b0 || edge_strobe_o !== 1'b1 || busy_o !== 1'b1) begin
      fails++; $display("FAIL restart_o1 got dout=%b strobe=%b busy=%b want 0,1,1", dout_o, edge_strobe_o, busy_o);
    end
    tests++; if (edge_cnt_o !== 8'd1) begin fails++; $display("FAIL restart_cnt got %0d want 1", edge_cnt_o); end
    tick();
    tests++; if (dout_o !== 1'b1 || edge_strobe_o !== 1'b0 || busy_o !== 1'b1) begin
      fails++; $display("FAIL restart_o2 got dout=%b strobe=%b busy=%b want 1,0,1", dout_o, edge_strobe_o, busy_o);
    end
    tick();
    tests++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin fails++; $display("FAIL restart_done got done=%b busy=%b want 1,0", done_o, busy_o); end
  endtask

  // low=2 high=2 edges=3 latched; inputs churn while busy; done at 13 only
  task automatic test_busy_ignore();
    logic e_dout, e_strb, e_done;
    int pos, ndone;
    low_len_i = 8'd2; high_len_i = 8'd2; num_edges_i = 8'd3;
    start_i = 1'b1;
    ndone = 0;
    for (int o = 1; o <= 16; o++) begin
      tick();
      start_i = (o == 2 || o == 5 || o == 9);
      if (o == 1) begin low_len_i = 8'd7; high_len_i = 8'd1; num_edges_i = 8'd9; end
      pos    = (o - 1) % 4;
      e_dout = (o <= 12) ? (pos >= 2) : 1'b1;
      e_strb = (o <= 12) && (pos == 0);
      e_done = (o == 13);
      tests++; if (dout_o !== e_dout) begin fails++; $display("FAIL busy_dout o=%0d got %b want %b", o, dout_o, e_dout); end
      tests++; if (edge_strobe_o !== e_strb) begin fails++; $display("FAIL busy_strobe o=%0d got %b want %b", o, edge_strobe_o, e_strb); end
      tests++; if (done_o !== e_done) begin fails++; $display("FAIL busy_done o=%0d got %b want %b", o, done_o, e_done); end
      if (done_o) ndone++;
    end
    start_i = 1'b0;
    tests++; if (ndone !== 1) begin fails++; $display("FAIL busy_done_count got %0d want 1", ndone); end
    tests++; if (edge_cnt_o !== 8'd3) begin fails++; $display("FAIL busy_cnt got %0d want 3", edge_cnt_o); end
  endtask

  task automatic test_rst_mid();
    low_len_i = 8'd1; high_len_i = 8'd3; num_edges_i = 8'd2;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tests++; if (dout_o !== 1'b1 || busy_o !== 1'b1) begin fails++; $display("FAIL rstmid_pre got dout=%b busy=%b want 1,1", dout_o, busy_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tests++; if (dout_o !== 1'b1) begin fails++; $display("FAIL rstmid_dout got %b want 1", dout_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL rstmid_done got %b want 0", done_o); end
    tests++; if (edge_cnt_o !== 8'd0) begin fails++; $display("FAIL rstmid_cnt got %0d want 0", edge_cnt_o); end
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (done_o !== 1'b0 || busy_o !== 1'b0 || dout_o !== 1'b1) begin
        fails++; $display("FAIL rstmid_quiet i=%0d got done=%b busy=%b dout=%b want 0,0,1", i, done_o, busy_o, dout_o);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    low_len_i = '0; high_len_i = '0; num_edges_i = '0;
    test_reset();
    test_basic();
    test_min_period();
    test_zero_edges();
    test_abort();
    tick();
    test_busy_ignore();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
